// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract unit: one full_adder_struc cell processes one bit per clock, LSB first.
// The carry sits in a flop between bits, and results are held from one completion to the next.

module full_adder_struc (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p_s;
  logic g_s;
  logic t_s;

  assign p_s  = a ^ b;
  assign g_s  = a & b;
  assign t_s  = p_s & cin;
  assign sum  = p_s ^ cin;
  assign cout = g_s | t_s;
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum_s;
  logic fa_cout_s;

  full_adder_struc u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand load, serial shift, and result capture on the last bit
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract is A + ~B + 1, so the inverted operand and the seed carry are loaded here
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end else begin
          a_sh_d  = a_sh_q;
        end
      end
      RUN: begin
        r_sh_d  = {fa_sum_s, r_sh_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_cout_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB on this step
          sum_d  = r_sh_d;
          cout_d = fa_cout_s;
          ovf_d  = carry_q ^ fa_cout_s;
        end else begin
          sum_d  = sum_q;
        end
      end
      DONE:    cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: a WIDTH=8 instance takes the directed vectors, and a WIDTH=2 instance is swept exhaustively.
// Stimulus pushes the expected results, and a negedge monitor pops and compares them on every done pulse.

module tb_serial_addsub_ctrl;
  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = 2'b00, b2 = 2'b00;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  exp_t q8[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  int   bcnt8 = 0;
  int   bcnt2 = 0;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_addsub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer add with signed overflow taken from the operand and result sign bits
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input int t);
    exp_t        e;
    logic [32:0] mask;
    logic [31:0] bb;
    logic [32:0] full;
    mask   = (33'd1 << w) - 33'd1;
    bb     = (sub ? ~b : b) & mask[31:0];
    full   = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    e.sum  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
    e.t    = t;
    return e;
  endfunction

  // Monitor: pops the scoreboard on each done pulse and checks result, latency and busy length
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (done8) begin
      chk("busy_done_excl8", {31'd0, busy8}, 32'd0);
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done8 actual=done expected=no_done");
      end else begin
        e = q8.pop_front();
        chk("sum8", {24'd0, sum8}, e.sum);
        chk("cout8", {31'd0, cout8}, {31'd0, e.cout});
        chk("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
        chk("latency8", ncyc, e.t);
        chk("busy_len8", bcnt8, 8);
      end
      bcnt8 = 0;
    end else if (busy8) begin
      bcnt8++;
    end else begin
      bcnt8 = 0;
    end
    if (q8.size() > 0 && ncyc > q8[0].t) begin
      e = q8.pop_front();
      checks++; errors++;
      $display("FAIL timeout8 actual=no_done expected_done_at=%0d", e.t);
    end

    if (done2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done2 actual=done expected=no_done");
      end else begin
        e = q2.pop_front();
        chk("sum2", {30'd0, sum2}, e.sum);
        chk("cout2", {31'd0, cout2}, {31'd0, e.cout});
        chk("ovf2", {31'd0, ovf2}, {31'd0, e.ovf});
        chk("latency2", ncyc, e.t);
        chk("busy_len2", bcnt2, 2);
      end
      bcnt2 = 0;
    end else if (busy2) begin
      bcnt2++;
    end else begin
      bcnt2 = 0;
    end
    if (q2.size() > 0 && ncyc > q2[0].t) begin
      e = q2.pop_front();
      checks++; errors++;
      $display("FAIL timeout2 actual=no_done expected_done_at=%0d", e.t);
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    @(posedge clk); #1;
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    e.sum = {24'd0, es}; e.cout = ec; e.ovf = eo; e.t = ncyc + 2 + 8;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = a ^ b; sub8 = ~s;
    repeat (9) @(posedge clk);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic s);
    @(posedge clk); #1;
    a2 = a; b2 = b; sub2 = s; start2 = 1'b1;
    q2.push_back(model(2, {30'd0, a}, {30'd0, b}, s, ncyc + 2 + 2));
    @(posedge clk); #1;
    start2 = 1'b0; a2 = ~a; b2 = ~b; sub2 = ~s;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_sum8", {24'd0, sum8}, 32'd0);
    chk("rst_cout_ovf8", {30'd0, cout8, ovf8}, 32'd0);
    chk("rst_out2", {27'd0, busy2, done2, sum2, cout2}, 32'd0);
    rst = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum8", {24'd0, sum8}, 32'd0);
      chk("hold_flags8", {30'd0, cout8, ovf8}, 32'd2);
      @(posedge clk); #1;
    end
    op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // start held high with operands changing every cycle: accepted edges are 0, 10, 20
    @(posedge clk); #1;
    c0 = ncyc;
    for (int j = 0; j < 3; j++) begin
      q8.push_back(model(8, (j * 10 * 37 + 5) & 32'hFF, (j * 10 * 91 + 3) & 32'hFF,
                         ((j * 10) % 3) == 1, c0 + 2 + 8 + 10 * j));
    end
    for (int i = 0; i < 30; i++) begin
      a8 = 8'((i * 37 + 5) & 255);
      b8 = 8'((i * 91 + 3) & 255);
      sub8 = ((i % 3) == 1);
      start8 = 1'b1;
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    repeat (10) @(posedge clk);

    // mid-run reset at the 4th RUN cycle of the op after a completed 0x5A+0x3C
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum", {24'd0, sum8}, 32'd0);
    chk("abort_flags", {30'd0, cout8, ovf8}, 32'd0);
    repeat (10) @(posedge clk);
    op8(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int s = 0; s < 2; s++) begin
          op2(2'(a), 2'(b), 1'(s));
        end
      end
    end

    repeat (5) @(posedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
